// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcodes, immediate formats and the decoded entry layout
package decode_pkg;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    imm_fmt_t    fmt;
    logic        rs1_used;
    logic        rs2_used;
    logic        bit20;
    logic        bit30;
    logic        illegal;
  } decoded_t;
endpackage

// File: rtl/decode_fields.sv
// decode_fields: combinational RV32I field, immediate and operand-use extraction
module decode_fields import decode_pkg::*; #(
  parameter bit ZERO_UNUSED = 1'b1
) (
  input  logic [31:0] inst,
  output decoded_t    dec
);
  logic [6:0] op;
  logic       s;
  logic       ill;
  imm_fmt_t   fmt;
  assign op  = inst[6:0];
  assign s   = inst[31];
  assign ill = !(op inside {OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM}) || inst[1:0] != 2'b11;
  assign fmt = op == OP ? FMT_R : op == STORE ? FMT_S : op == BRANCH ? FMT_B :
               (op == LUI || op == AUIPC) ? FMT_U : op == JAL ? FMT_J : FMT_I;
  always_comb begin
    dec          = '0;
    dec.opcode   = op;
    dec.rd       = fmt inside {FMT_S, FMT_B} ? 5'd0 : inst[11:7];
    dec.rs1      = (ZERO_UNUSED && fmt inside {FMT_U, FMT_J}) ? 5'd0 : inst[19:15];
    dec.rs2      = (ZERO_UNUSED && !(fmt inside {FMT_R, FMT_S, FMT_B})) ? 5'd0 : inst[24:20];
    dec.funct3   = inst[14:12];
    dec.funct7   = inst[31:25];
    dec.imm      = fmt == FMT_I ? {{20{s}}, inst[31:20]} :
                   fmt == FMT_S ? {{20{s}}, inst[31:25], inst[11:7]} :
                   fmt == FMT_B ? {{19{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0} :
                   fmt == FMT_U ? {inst[31:12], 12'b0} :
                   fmt == FMT_J ? {{11{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0} : 32'd0;
    dec.fmt      = fmt;
    dec.rs1_used = !ill && !(fmt inside {FMT_U, FMT_J});
    dec.rs2_used = !ill && fmt inside {FMT_R, FMT_S, FMT_B};
    dec.bit20    = inst[20];
    dec.bit30    = inst[30];
    dec.illegal  = ill;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a DEPTH-entry output FIFO and flush
module decode_stage import decode_pkg::*; #(
  parameter int DEPTH       = 2,
  parameter int PC_W        = 32,
  parameter bit ZERO_UNUSED = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_bit20,
  output logic            out_bit30,
  output logic            out_illegal
);
  decoded_t        dec;
  decoded_t        cur;
  decoded_t        mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            push;
  logic            pop;
  function automatic logic nxt(input logic p);
    return DEPTH == 1 ? 1'b0 : !p;
  endfunction
  decode_fields #(.ZERO_UNUSED(ZERO_UNUSED)) u_fields (.inst(in_inst), .dec(dec));
  assign in_ready  = count < 2'(DEPTH) || (DEPTH == 1 && out_ready);
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]    <= '0;
        pc_mem[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]    <= dec;
        pc_mem[wr_ptr] <= in_pc;
        wr_ptr         <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign cur          = mem[rd_ptr];
  assign out_pc       = pc_mem[rd_ptr];
  assign out_opcode   = cur.opcode;
  assign out_rd       = cur.rd;
  assign out_rs1      = cur.rs1;
  assign out_rs2      = cur.rs2;
  assign out_funct3   = cur.funct3;
  assign out_funct7   = cur.funct7;
  assign out_imm      = cur.imm;
  assign out_fmt      = cur.fmt;
  assign out_rs1_used = cur.rs1_used;
  assign out_rs2_used = cur.rs2_used;
  assign out_bit20    = cur.bit20;
  assign out_bit30    = cur.bit30;
  assign out_illegal  = cur.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (DEPTH=2)
module tb_decode_stage;
  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] SW    = 32'hFE20AE23;
  localparam logic [31:0] LUI_I = 32'h123452B7;
  localparam logic [31:0] JAL_I = 32'hFF9FF06F;
  localparam logic [31:0] ADD_I = 32'h002081B3;
  localparam logic [31:0] BEQ_I = 32'hFE208EE3;
  localparam logic [31:0] PROG [7] = '{ADDI, SW, LUI_I, JAL_I, 32'h0, ADD_I, BEQ_I};
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        r1u, r2u, ill;
  } exp_t;
  logic        clk = 0, resetn = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [31:0] in_inst = '0, in_pc = '0, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic        out_rs1_used, out_rs2_used, out_bit20, out_bit30, out_illegal;
  exp_t        q[$];
  int          checks = 0, passed = 0;
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_bit20(out_bit20), .out_bit30(out_bit30), .out_illegal(out_illegal)
  );
  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    case (inst)
      ADDI:    {e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill} = {5'd1, 5'd0, 5'd0, 32'h00000005, 3'd1, 3'b100};
      SW:      {e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill} = {5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 3'd2, 3'b110};
      LUI_I:   {e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill} = {5'd5, 5'd0, 5'd0, 32'h12345000, 3'd4, 3'b000};
      JAL_I:   {e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill} = {5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 3'd5, 3'b000};
      ADD_I:   {e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill} = {5'd3, 5'd1, 5'd2, 32'h00000000, 3'd0, 3'b110};
      BEQ_I:   {e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill} = {5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 3'd3, 3'b110};
      default: {e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill} = {5'd0, 5'd0, 5'd0, 32'h00000000, 3'd1, 3'b001};
    endcase
    return e;
  endfunction
  task automatic test_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, out_pc, out_imm, out_rd, out_fmt} !== {1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 3'd0})
      $display("FAIL reset got valid=%b ready=%b pc=%h imm=%h rd=%0d fmt=%0d required 0 1 0 0 0 0",
               out_valid, in_ready, out_pc, out_imm, out_rd, out_fmt);
    else passed++;
    resetn = 1;
  endtask
  task automatic test_decode();
    int   b = 0;
    exp_t e;
    out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = b < 7;
      in_inst  = PROG[b < 7 ? b : 0];
      in_pc    = 32'(b * 4);
      @(negedge clk);
      if (c >= 1 && c <= 7) begin
        checks++;
        if (out_valid !== 1'b1) $display("FAIL decode_latency cycle=%0d got out_valid=%b required 1", c, out_valid);
        else passed++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL decode_extra got pc=%h required no entry", out_pc);
        else begin
          e = q.pop_front();
          if ({out_pc, out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_rs1_used, out_rs2_used, out_illegal} !==
              {e.pc, e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill})
            $display("FAIL decode inst=%h got pc=%h rd=%0d rs1=%0d rs2=%0d imm=%h fmt=%0d use=%b%b ill=%b required pc=%h rd=%0d rs1=%0d rs2=%0d imm=%h fmt=%0d use=%b%b ill=%b",
                     e.inst, out_pc, out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_rs1_used, out_rs2_used, out_illegal,
                     e.pc, e.rd, e.rs1, e.rs2, e.imm, e.fmt, e.r1u, e.r2u, e.ill);
          else passed++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(mk(in_inst, in_pc));
        b++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    checks++;
    if (q.size() != 0 || b != 7) $display("FAIL decode_drain got left=%0d sent=%0d required 0 7", q.size(), b);
    else passed++;
  endtask
  task automatic test_backpressure();
    int   b = 0;
    exp_t e;
    for (int c = 0; c < 10; c++) begin
      in_valid  = b < 3;
      in_inst   = SW;
      in_pc     = 32'(b * 4);
      out_ready = c >= 4;
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (in_ready !== 1'b0 || b != 2) $display("FAIL bp_full got in_ready=%b accepted=%0d required 0 2", in_ready, b);
        else passed++;
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (out_pc !== 32'h0 || out_imm !== 32'hFFFFFFFC) $display("FAIL bp_hold got pc=%h imm=%h required 00000000 fffffffc", out_pc, out_imm);
        else passed++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL bp_extra got pc=%h required no entry", out_pc);
        else begin
          e = q.pop_front();
          if ({out_pc, out_imm, out_rs2} !== {e.pc, e.imm, e.rs2})
            $display("FAIL bp_order got pc=%h imm=%h rs2=%0d required pc=%h imm=%h rs2=%0d", out_pc, out_imm, out_rs2, e.pc, e.imm, e.rs2);
          else passed++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(mk(in_inst, in_pc));
        b++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    checks++;
    if (q.size() != 0 || b != 3) $display("FAIL bp_drain got left=%0d sent=%0d required 0 3", q.size(), b);
    else passed++;
  endtask
  task automatic test_flush();
    bit seen = 0;
    out_ready = 0;
    in_valid  = 1;
    in_inst   = ADDI;
    in_pc     = 32'h100;
    @(posedge clk); #1;
    in_pc = 32'h104;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL flush_fill got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    else passed++;
    flush = 1;
    in_pc = 32'h108;
    @(posedge clk); #1;
    flush = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_full got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    else passed++;
    in_pc = 32'h10C;
    flush = 1;
    @(posedge clk); #1;
    flush    = 0;
    in_valid = 0;
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) $display("FAIL flush_drop got out_valid=1 required 0 after flush");
    else passed++;
    @(posedge clk); #1;
    in_valid = 1;
    in_inst  = JAL_I;
    in_pc    = 32'h110;
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if ({out_valid, out_pc, out_imm, out_fmt} !== {1'b1, 32'h110, 32'hFFFFFFF8, 3'd5})
      $display("FAIL flush_resume got valid=%b pc=%h imm=%h fmt=%0d required 1 00000110 fffffff8 5", out_valid, out_pc, out_imm, out_fmt);
    else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_midreset();
    out_ready = 0;
    in_valid  = 1;
    in_inst   = SW;
    in_pc     = 32'h1F0;
    @(posedge clk); #1;
    in_pc = 32'h1F4;
    @(posedge clk); #1;
    resetn = 0;
    in_pc  = 32'h1F8;
    @(posedge clk); #1;
    resetn   = 1;
    in_valid = 0;
    checks++;
    if ({out_valid, in_ready, out_imm, out_pc, out_rs2} !== {1'b0, 1'b1, 32'h0, 32'h0, 5'd0})
      $display("FAIL midreset got valid=%b ready=%b imm=%h pc=%h rs2=%0d required 0 1 0 0 0", out_valid, in_ready, out_imm, out_pc, out_rs2);
    else passed++;
    out_ready = 1;
    in_valid  = 1;
    in_inst   = LUI_I;
    in_pc     = 32'h200;
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if ({out_valid, out_pc, out_imm, out_rd} !== {1'b1, 32'h200, 32'h12345000, 5'd5})
      $display("FAIL midreset_resume got valid=%b pc=%h imm=%h rd=%0d required 1 00000200 12345000 5", out_valid, out_pc, out_imm, out_rd);
    else passed++;
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
